gf163_mul_sched: RTL and testbench

//  Shares one combinational GF(2^163) Karatsuba multiplier (karatsuba_163x163, reduced mod
//  f(x)=x^163+x^7+x^6+x^3+1) between NREQ requesters (point-add/double sequencers, inversion unit).
//  - Round-robin arbitration; operand and result are registered.
//  - Each result is returned tagged with the requester index.
//  - Sits between the ECC control sequencers and the field multiplier.

---
 rtl/gf163_pkg.sv | 18 +
 rtl/gf163_mul_sched_rr_arbiter.sv | 44 ++++
 rtl/karatsuba_163x163.sv | 51 +++++
 rtl/gf163_mul_sched.sv | 118 +++++++++++
 tb/tb_gf163_mul_sched.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf163_pkg.sv
// Shared types and constants for the GF(2^163) multiplier scheduler.
// Field: f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package gf163_pkg;

    localparam int GF_M = 163;
    localparam logic [162:0] GF_POLY_LOW = 163'hC9;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        HOLD
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gf163_mul_sched_rr_arbiter.sv
// Round-robin arbiter; remembers the last granted index and
// searches from the one after it.
module rr_arbiter
    import gf163_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    logic [IDW-1:0] last;
    logic           found;
    int             j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last) + k) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
            end
        end
    end

    // Reset to N-1 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= IDW'(N-1);
        else if (advance)
            last <= grant_idx;
    end

endmodule

// File: rtl/karatsuba_163x163.sv
// Combinational GF(2^163) multiplier: one Karatsuba split, then
// reduction of the 325-bit carry-less product mod f(x).
module karatsuba_163x163
    import gf163_pkg::*;
(
    input  logic [GF_M-1:0] a,
    input  logic [GF_M-1:0] b,
    output logic [GF_M-1:0] p
);

    localparam int H = 82;

    function automatic logic [2*H-1:0] clmul(
        input logic [H-1:0] x,
        input logic [H-1:0] y
    );
        logic [2*H-1:0] r;
        r = '0;
        for (int i = 0; i < H; i++)
            if (y[i])
                r = r ^ ({{H{1'b0}}, x} << i);
        return r;
    endfunction

    logic [H-1:0]   a0, a1, b0, b1;
    logic [2*H-1:0] z0, z1, z2;
    logic [4*H-1:0] full;

    assign a0 = a[H-1:0];
    assign b0 = b[H-1:0];
    assign a1 = {1'b0, a[GF_M-1:H]};
    assign b1 = {1'b0, b[GF_M-1:H]};

    assign z0 = clmul(a0, b0);
    assign z2 = clmul(a1, b1);
    assign z1 = clmul(a0 ^ a1, b0 ^ b1) ^ z0 ^ z2;

    // Fold high bits from the top down; x^163 == x^7+x^6+x^3+1.
    always_comb begin
        full = {{2*H{1'b0}}, z0}
             ^ ({{2*H{1'b0}}, z1} << H)
             ^ ({{2*H{1'b0}}, z2} << 2*H);
        for (int i = 4*H-1; i >= GF_M; i--)
            if (full[i])
                full = full
                     ^ ({{(4*H-GF_M){1'b0}}, GF_POLY_LOW} << (i-GF_M))
                     ^ ({{(4*H-1){1'b0}}, 1'b1} << i);
        p = full[GF_M-1:0];
    end

endmodule

// File: rtl/gf163_mul_sched.sv
// Round-robin scheduler sharing one GF(2^163) multiplier among NREQ users.
// Define GF163_MUL_STATS_EN to add grant_cnt / stall_cnt statistics ports.
module gf163_mul_sched
    import gf163_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = clog2_min1(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*GF_M-1:0] req_a,
    input  logic [NREQ*GF_M-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [GF_M-1:0]      rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
`ifdef GF163_MUL_STATS_EN
    ,
    output logic [NREQ*16-1:0]   grant_cnt,
    output logic [15:0]          stall_cnt
`endif
);

    state_t          state_q, state_d;
    logic            can_grant, hs;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx, id_q;
    logic [GF_M-1:0] a_q, b_q, a_sel, b_sel, prod;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (hs),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    karatsuba_163x163 u_mul (
        .a (a_q),
        .b (b_q),
        .p (prod)
    );

    // Grants are suppressed while reset is held so nothing is accepted.
    assign can_grant = rst_n &&
                       (state_q == IDLE ||
                        (state_q == HOLD && rsp_ready));
    assign req_ready = can_grant ? grant : '0;
    assign hs        = |req_ready;
    assign busy      = (state_q != IDLE);

    assign a_sel = req_a[int'(grant_idx)*GF_M +: GF_M];
    assign b_sel = req_b[int'(grant_idx)*GF_M +: GF_M];

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (hs) state_d = EVAL;
            EVAL: state_d = HOLD;
            HOLD: if (rsp_ready) state_d = hs ? EVAL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (hs) begin
                a_q  <= a_sel;
                b_q  <= b_sel;
                id_q <= grant_idx;
            end
            if (state_q == EVAL) begin
                rsp_data  <= prod;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end else if (state_q == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef GF163_MUL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            if (state_q == HOLD && !rsp_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gf163_mul_sched.sv
// Self-checking bench for gf163_mul_sched against a bit-serial GF(2^163) model.
module tb_gf163_mul_sched;
    import gf163_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*GF_M-1:0] req_a = '0;
    logic [NREQ*GF_M-1:0] req_b = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [GF_M-1:0]      rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;
`ifdef GF163_MUL_STATS_EN
    logic [NREQ*16-1:0]   grant_cnt;
    logic [15:0]          stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    gf163_mul_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef GF163_MUL_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Shift-and-add multiply with reduction at every step.
    function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
        logic [162:0] r;
        r = '0;
        for (int i = 162; i >= 0; i--) begin
            if (r[162]) r = {r[161:0], 1'b0} ^ 163'hC9;
            else        r = {r[161:0], 1'b0};
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[162:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [162:0] a, input logic [162:0] b);
        req_a[idx*GF_M +: GF_M] = a;
        req_b[idx*GF_M +: GF_M] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One request; HOLD lasts `stalls` cycles with rsp_ready low.
    task automatic do_op(input int idx, input logic [162:0] a, input logic [162:0] b,
                         input int stalls, input string name);
        logic [162:0]    exp;
        logic [NREQ-1:0] oh;
        logic [IDW-1:0]  eid;
        exp = gf_mul(a, b);
        oh = '0;
        oh[idx] = 1'b1;
        eid = IDW'(idx);
        set_ops(idx, a, b);
        req_valid = oh;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== oh) begin
            failures++;
            $display("FAIL %s_grant req_ready=%b expected=%b", name, req_ready, oh);
        end
        step();
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_eval rsp_valid=%b busy=%b expected 0,1", name, rsp_valid, busy);
        end
        step();
        rsp_ready = (stalls == 0);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_id !== eid) begin
            failures++;
            $display("FAIL %s_rsp valid=%b id=%0d data=%h expected id=%0d data=%h",
                     name, rsp_valid, rsp_id, rsp_data, eid, exp);
        end
        for (int s = 1; s <= stalls; s++) begin
            step();
            rsp_ready = (s == stalls);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_id !== eid ||
                (s < stalls && req_ready !== '0)) begin
                failures++;
                $display("FAIL %s_stall%0d valid=%b id=%0d ready=%b data=%h expected=%h",
                         name, s, rsp_valid, rsp_id, req_ready, rsp_data, exp);
            end
        end
        step();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done rsp_valid=%b busy=%b expected 0,0", name, rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 ||
            req_ready !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset valid=%b data=%h id=%0d ready=%b busy=%b expected all 0",
                     rsp_valid, rsp_data, rsp_id, req_ready, busy);
        end
    endtask

    task automatic test_single();
        logic [162:0] a, b;
        a = 163'd1;
        b = 163'd2;
        do_op(0, a, b, 0, "single");
        checks++;
        if (rsp_data !== 163'd2) begin
            failures++;
            $display("FAIL single_value rsp_data=%h expected=2", rsp_data);
        end
    endtask

    task automatic test_reduction();
        logic [162:0] a, b;
        a = 163'd1 << 162;
        b = 163'd2;
        do_op(1, a, b, 0, "reduce_top");
        checks++;
        if (rsp_data !== 163'hC9) begin
            failures++;
            $display("FAIL reduce_const rsp_data=%h expected=c9", rsp_data);
        end
        a = '1;
        do_op(0, a, a, 1, "reduce_ones");
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++)
            do_op(int'($urandom_range(0, NREQ-1)), rand163(), rand163(),
                  int'($urandom_range(0, 2)), "random");
    endtask

    task automatic test_fairness();
        logic [162:0]    opa[NREQ];
        logic [162:0]    opb[NREQ];
        logic [162:0]    exp_q[$];
        int              id_q[$];
        logic [NREQ-1:0] oh;
        int              grants, cyc, act;
        logic [162:0]    e;
        int              eid;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = rand163();
            opb[i] = rand163();
            set_ops(i, opa[i], opb[i]);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        grants = 0;
        cyc = 0;
        while ((grants < 8 || exp_q.size() > 0) && cyc < 60) begin
            #1;
            act = -1;
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL fair_extra unexpected response id=%0d", rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    eid = id_q.pop_front();
                    if (rsp_data !== e || int'(rsp_id) != eid) begin
                        failures++;
                        $display("FAIL fair_rsp id=%0d data=%h expected id=%0d data=%h",
                                 rsp_id, rsp_data, eid, e);
                    end
                end
            end
            if (|req_ready) begin
                oh = '0;
                oh[grants % 2] = 1'b1;
                checks++;
                if (req_ready !== oh) begin
                    failures++;
                    $display("FAIL fair_order grant%0d req_ready=%b expected=%b",
                             grants, req_ready, oh);
                end
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i] && act < 0) act = i;
                exp_q.push_back(gf_mul(opa[act], opb[act]));
                id_q.push_back(act);
                grants++;
            end
            step();
            cyc++;
            if (act >= 0) begin
                opa[act] = rand163();
                opb[act] = rand163();
                set_ops(act, opa[act], opb[act]);
            end
            if (grants >= 8) req_valid = '0;
        end
        checks++;
        if (grants != 8 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL fair_timeout grants=%0d pending=%0d expected 8,0",
                     grants, exp_q.size());
        end
        rsp_ready = 1'b0;
        step();
    endtask

    task automatic test_back_pressure();
        logic [162:0] a0, b0, a1, b1, e0, e1;
        do_reset();
        a0 = rand163(); b0 = rand163();
        a1 = rand163(); b1 = rand163();
        e0 = gf_mul(a0, b0);
        e1 = gf_mul(a1, b1);
        set_ops(0, a0, b0);
        req_valid = 2'b01;
        #1;
        step();
        set_ops(1, a1, b1);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL bp_eval_ready req_ready=%b expected=00", req_ready);
        end
        step();
        #1;
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== e0 || rsp_id !== 1'b0 ||
                req_ready !== 2'b00) begin
                failures++;
                $display("FAIL bp_hold%0d valid=%b id=%0d ready=%b data=%h expected=%h",
                         s, rsp_valid, rsp_id, req_ready, rsp_data, e0);
            end
            step();
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL bp_release req_ready=%b expected=10", req_ready);
        end
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drop rsp_valid=%b expected=0", rsp_valid);
        end
        step();
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== e1 || rsp_id !== 1'b1) begin
            failures++;
            $display("FAIL bp_second valid=%b id=%0d data=%h expected id=1 data=%h",
                     rsp_valid, rsp_id, rsp_data, e1);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle busy=%b expected=0", busy);
        end
    endtask

    task automatic test_reset_in_eval();
        logic [162:0] a, b;
        a = rand163();
        b = rand163();
        set_ops(0, a, b);
        req_valid = 2'b01;
        #1;
        step();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL rst_eval_ready req_ready=%b expected=00", req_ready);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 ||
            req_ready !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_eval_outs valid=%b data=%h id=%0d ready=%b busy=%b expected all 0",
                     rsp_valid, rsp_data, rsp_id, req_ready, busy);
        end
        for (int s = 0; s < 3; s++) begin
            step();
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rst_eval_quiet%0d rsp_valid=%b busy=%b expected 0,0",
                         s, rsp_valid, busy);
            end
        end
        set_ops(1, rand163(), rand163());
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL rst_eval_prio req_ready=%b expected=01", req_ready);
        end
        do_op(0, a, b, 0, "after_reset");
    endtask

`ifdef GF163_MUL_STATS_EN
    task automatic test_stats();
        do_reset();
        do_op(1, rand163(), rand163(), 4, "stats_a");
        do_op(1, rand163(), rand163(), 0, "stats_b");
        do_op(1, rand163(), rand163(), 0, "stats_c");
        checks++;
        if (grant_cnt[31:16] !== 16'd3 || grant_cnt[15:0] !== 16'd0 ||
            stall_cnt !== 16'd4) begin
            failures++;
            $display("FAIL stats grant1=%0d grant0=%0d stall=%0d expected 3,0,4",
                     grant_cnt[31:16], grant_cnt[15:0], stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_reduction();
        test_random();
        test_fairness();
        test_back_pressure();
        test_reset_in_eval();
`ifdef GF163_MUL_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
